// File: rtl/cipher_dispatch_pkg.sv
// Shared types and helper constants for the cipher dispatch block.
// Holds the serializer state encoding and the word/byte ratio helpers.
// No ports; imported by cipher_dispatch and cipher_dispatch_fifo.
package cipher_dispatch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Number of bytes carried by one master word.
    function automatic int calc_ratio(input int mst_w, input int sys_w);
        return mst_w / sys_w;
    endfunction

    // Width of the byte index counter; never narrower than one bit.
    function automatic int calc_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int DEF_MST_DWIDTH = 32;
    localparam int DEF_SYS_DWIDTH = 8;
    localparam int DEF_RATIO      = calc_ratio(DEF_MST_DWIDTH, DEF_SYS_DWIDTH);
    localparam int DEF_IDX_W      = calc_idx_w(DEF_RATIO);

endpackage

// File: rtl/cipher_dispatch_fifo.sv
// Input word FIFO for the cipher dispatcher (power-of-two depth).
// Ports: push_i/wdata_i write side, pop_i/rdata_o read side (show-ahead),
// full_o (registered), empty_o, occ_o occupancy. Push while full is ignored.
module cipher_dispatch_fifo
    import cipher_dispatch_pkg::*;
#(
    parameter int WIDTH = DEF_MST_DWIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   occ_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      occ_q;
    logic [AW:0]      occ_d;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (occ_q != '0);

    // Push and pop together leave the count untouched.
    always_comb begin
        occ_d = occ_q;
        unique case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            occ_q  <= occ_d;
            // Full flag follows the registered count, so a pop in a full
            // cycle only releases it on the following cycle.
            full_q <= (occ_d == (AW+1)'(DEPTH));
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (occ_q == '0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/cipher_dispatch.sv
// Splits master words into bytes (MSB first) for NUM_CH cipher engines and
// merges the engine results back into one byte stream on data_o/valid_o.
// Ports: select/data_i/valid_i/busy word input, ch_* engine side,
// data_o/valid_o merged output, sel_error invalid-select pulse.
// Optional bypass channel (select == NUM_CH) enabled by CIPHER_DISPATCH_BYPASS_EN.
module cipher_dispatch
    import cipher_dispatch_pkg::*;
#(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8,
    parameter int NUM_CH     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_W      = 2
) (
    input  logic                         clk_sys,
    input  logic                         rst_n,
    input  logic [SEL_W-1:0]             select,
    input  logic [MST_DWIDTH-1:0]        data_i,
    input  logic                         valid_i,
    output logic                         busy,
    output logic [NUM_CH*SYS_DWIDTH-1:0] ch_data_o,
    output logic [NUM_CH-1:0]            ch_valid_o,
    input  logic [NUM_CH-1:0]            ch_busy_i,
    input  logic [NUM_CH*SYS_DWIDTH-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]            ch_valid_i,
    output logic [SYS_DWIDTH-1:0]        data_o,
    output logic                         valid_o,
    output logic                         sel_error
);

    localparam int RATIO = calc_ratio(MST_DWIDTH, SYS_DWIDTH);
    localparam int IDX_W = calc_idx_w(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [MST_DWIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OCC_W-1:0]      fifo_occ;

    assign fifo_push = valid_i && !fifo_full;

    cipher_dispatch_fifo #(
        .WIDTH (MST_DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .occ_o   (fifo_occ)
    );

    assign busy = fifo_full;

    assert property (@(posedge clk_sys) disable iff (!rst_n)
        (int'(fifo_occ) <= FIFO_DEPTH) && (busy == (int'(fifo_occ) == FIFO_DEPTH)));

    // ------------------------------------------------------------------
    // Select helpers
    // ------------------------------------------------------------------
    function automatic logic sel_valid(input logic [SEL_W-1:0] s);
`ifdef CIPHER_DISPATCH_BYPASS_EN
        return int'(s) <= NUM_CH;
`else
        return int'(s) < NUM_CH;
`endif
    endfunction

    // Busy of the addressed engine; the bypass path is never busy.
    function automatic logic sel_busy(input logic [SEL_W-1:0] s,
                                      input logic [NUM_CH-1:0] b);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(s) == k) begin
                r = b[k];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    ser_state_e                   state_q, state_d;
    logic [MST_DWIDTH-1:0]        shreg_q, shreg_d;
    logic [IDX_W-1:0]             bidx_q, bidx_d;
    logic [SEL_W-1:0]             cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]             res_sel_q, res_sel_d;
    logic [NUM_CH*SYS_DWIDTH-1:0] ch_data_q, ch_data_d;
    logic [NUM_CH-1:0]            ch_valid_q, ch_valid_d;
    logic                         sel_err_q, sel_err_d;
    logic [SYS_DWIDTH-1:0]        data_q;
    logic                         valid_q;
    logic [SYS_DWIDTH-1:0]        cur_byte;
    logic                         take;
`ifdef CIPHER_DISPATCH_BYPASS_EN
    logic                         byp_vld_q, byp_vld_d;
    logic [SYS_DWIDTH-1:0]        byp_dat_q, byp_dat_d;
`endif

    assign cur_byte = shreg_q[MST_DWIDTH-1 -: SYS_DWIDTH];

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bidx_d     = bidx_q;
        cur_sel_d  = cur_sel_q;
        res_sel_d  = res_sel_q;
        ch_data_d  = ch_data_q;
        ch_valid_d = '0;
        sel_err_d  = 1'b0;
        fifo_pop   = 1'b0;
        take       = 1'b0;
`ifdef CIPHER_DISPATCH_BYPASS_EN
        byp_vld_d  = 1'b0;
        byp_dat_d  = byp_dat_q;
`endif

        unique case (state_q)
            IDLE: take = 1'b1;
            SEND: begin
                if (!sel_busy(cur_sel_q, ch_busy_i)) begin
`ifdef CIPHER_DISPATCH_BYPASS_EN
                    if (int'(cur_sel_q) == NUM_CH) begin
                        byp_vld_d = 1'b1;
                        byp_dat_d = cur_byte;
                    end
`endif
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (int'(cur_sel_q) == k) begin
                            ch_valid_d[k] = 1'b1;
                            ch_data_d[k*SYS_DWIDTH +: SYS_DWIDTH] = cur_byte;
                        end
                    end
                    // Results are routed by the channel of the last byte
                    // sent, so the tail of a word survives a channel switch.
                    res_sel_d = cur_sel_q;
                    shreg_d   = shreg_q << SYS_DWIDTH;
                    bidx_d    = bidx_q + IDX_W'(1);
                    if (bidx_q == LAST_IDX) begin
                        state_d = IDLE;
                        take    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A word stays queued while its target engine is busy, so buffered
        // words wait in the FIFO rather than in the shift register.
        if (take && !fifo_empty) begin
            if (!sel_valid(select)) begin
                fifo_pop  = 1'b1;
                sel_err_d = 1'b1;
            end else if (!sel_busy(select, ch_busy_i)) begin
                fifo_pop  = 1'b1;
                shreg_d   = fifo_rdata;
                bidx_d    = '0;
                cur_sel_d = select;
                state_d   = SEND;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result merge
    // ------------------------------------------------------------------
    logic                  res_vld;
    logic [SYS_DWIDTH-1:0] res_dat;

    always_comb begin
        res_vld = 1'b0;
        res_dat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(res_sel_q) == k) begin
                res_vld = ch_valid_i[k];
                res_dat = ch_data_i[k*SYS_DWIDTH +: SYS_DWIDTH];
            end
        end
`ifdef CIPHER_DISPATCH_BYPASS_EN
        if (int'(res_sel_q) == NUM_CH) begin
            res_vld = byp_vld_q;
            res_dat = byp_dat_q;
        end
`endif
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bidx_q     <= '0;
            cur_sel_q  <= '0;
            res_sel_q  <= '0;
            ch_data_q  <= '0;
            ch_valid_q <= '0;
            sel_err_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
`ifdef CIPHER_DISPATCH_BYPASS_EN
            byp_vld_q  <= 1'b0;
            byp_dat_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bidx_q     <= bidx_d;
            cur_sel_q  <= cur_sel_d;
            res_sel_q  <= res_sel_d;
            ch_data_q  <= ch_data_d;
            ch_valid_q <= ch_valid_d;
            sel_err_q  <= sel_err_d;
            valid_q    <= res_vld;
            if (res_vld) begin
                data_q <= res_dat;
            end
`ifdef CIPHER_DISPATCH_BYPASS_EN
            byp_vld_q  <= byp_vld_d;
            byp_dat_q  <= byp_dat_d;
`endif
        end
    end

    assign ch_data_o  = ch_data_q;
    assign ch_valid_o = ch_valid_q;
    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign sel_error  = sel_err_q;

endmodule

// File: tb/tb_cipher_dispatch.sv
module tb_cipher_dispatch;

    localparam int MW   = 32;
    localparam int SW   = 8;
    localparam int NCH  = 3;
    localparam int FD   = 4;
    localparam int SELW = 2;
    localparam logic [7:0] KEY = 8'h5A;

    logic              clk_sys = 1'b0;
    logic              rst_n   = 1'b0;
    logic [SELW-1:0]   select  = '0;
    logic [MW-1:0]     data_i  = '0;
    logic              valid_i = 1'b0;
    logic              busy;
    logic [NCH*SW-1:0] ch_data_o;
    logic [NCH-1:0]    ch_valid_o;
    logic [NCH-1:0]    ch_busy_i = '0;
    logic [NCH*SW-1:0] ch_data_i;
    logic [NCH-1:0]    ch_valid_i;
    logic [SW-1:0]     data_o;
    logic              valid_o;
    logic              sel_error;
    logic [NCH-1:0]    noise = '0;

    always #5 clk_sys = ~clk_sys;

    // Engine model: answers in the same cycle with byte XOR KEY.
    assign ch_valid_i = ch_valid_o | noise;
    assign ch_data_i  = ch_data_o ^ {NCH{KEY}};

    cipher_dispatch #(
        .MST_DWIDTH (MW), .SYS_DWIDTH (SW), .NUM_CH (NCH),
        .FIFO_DEPTH (FD), .SEL_W (SELW)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .select     (select),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .busy       (busy),
        .ch_data_o  (ch_data_o),
        .ch_valid_o (ch_valid_o),
        .ch_busy_i  (ch_busy_i),
        .ch_data_i  (ch_data_i),
        .ch_valid_i (ch_valid_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .sel_error  (sel_error)
    );

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] dat;
    } ch_exp_t;

    ch_exp_t    ch_q[$];
    logic [7:0] out_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the bytes a word should produce: engine bytes plus decrypted
    // results for a real channel, raw bytes on data_o for the bypass channel.
    task automatic expect_word(input logic [31:0] w, input int ch);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[31-8*i -: 8];
            if (ch < NCH) begin
                ch_q.push_back({8'(ch), b});
                out_q.push_back(b ^ KEY);
            end else begin
                out_q.push_back(b);
            end
        end
    endtask

    // Called at posedge+1; the word is presented for exactly one edge.
    task automatic send_word(input logic [31:0] w, input logic [SELW-1:0] s);
        data_i  = w;
        select  = s;
        valid_i = 1'b1;
        @(posedge clk_sys); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && (ch_q.size() != 0 || out_q.size() != 0); i++) begin
            @(posedge clk_sys);
        end
        check(name, 32'(ch_q.size() + out_q.size()), 32'd0);
        repeat (3) @(posedge clk_sys);
        #1;
    endtask

    // Monitor / scoreboard
    ch_exp_t    mon_e;
    logic [7:0] mon_b;
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (ch_valid_o != '0) begin
                if (ch_q.size() == 0) begin
                    check("unexpected_ch_strobe", 32'(ch_valid_o), 32'd0);
                end else begin
                    mon_e = ch_q.pop_front();
                    check("ch_strobe", 32'(ch_valid_o), 32'd1 << mon_e.ch);
                    check("ch_byte", 32'((ch_data_o >> (32'(mon_e.ch) * 8)) & 24'hFF), 32'(mon_e.dat));
                end
            end
            if (valid_o) begin
                if (out_q.size() == 0) begin
                    check("unexpected_valid_o", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    mon_b = out_q.pop_front();
                    check("data_o", 32'(data_o), 32'(mon_b));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] words [5];
    int          run;
    int          lat;

    initial begin
        words[0] = 32'h01020304;
        words[1] = 32'h05060708;
        words[2] = 32'h090A0B0C;
        words[3] = 32'h0D0E0F10;
        words[4] = 32'hDEADBEEF;

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ch_valid", 32'(ch_valid_o), 32'd0);
        check("rst_ch_data", 32'(ch_data_o), 32'd0);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);
        check("rst_sel_error", 32'(sel_error), 32'd0);
        @(posedge clk_sys); #3;
        rst_n = 1'b1;
        @(posedge clk_sys); #1;

        // Single word to channel 1, cycle-exact latency; ch2 result strobe is noise
        noise = 3'b100;
        expect_word(32'h11223344, 1);
        send_word(32'h11223344, 2'd1);
        check("lat_cycle_n", 32'(ch_valid_o), 32'd0);
        @(posedge clk_sys); #1;
        check("lat_cycle_n1", 32'(ch_valid_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_sys); #1;
            check("w1_strobe", 32'(ch_valid_o), 32'b010);
            check("w1_byte", 32'(ch_data_o[15:8]), 32'(8'h11 * (i + 1) + ((i + 1) * 8'h11)) >> 1);
        end
        @(posedge clk_sys); #1;
        check("w1_done", 32'(ch_valid_o), 32'd0);
        wait_drain("w1_drain");
        noise = '0;

        // FIFO fill with all engines busy, fifth word dropped
        ch_busy_i = 3'b111;
        select    = 2'd0;
        for (int i = 0; i < 5; i++) begin
            data_i  = words[i];
            valid_i = 1'b1;
            check("fill_busy", 32'(busy), (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) expect_word(words[i], 0);
            @(posedge clk_sys); #1;
        end
        valid_i = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        check("fill_busy_held", 32'(busy), 32'd1);
        check("fill_no_strobe", 32'(ch_valid_o), 32'd0);
        ch_busy_i = '0;
        lat = 0;
        while (ch_valid_o == '0 && lat < 20) begin
            @(posedge clk_sys); #1;
            lat++;
        end
        run = 0;
        while (ch_valid_o == 3'b001 && run < 20) begin
            run++;
            @(posedge clk_sys); #1;
        end
        check("fill_run_length", 32'(run), 32'd16);
        wait_drain("fill_drain");
        check("fill_busy_clear", 32'(busy), 32'd0);

        // Engine 0 stalls for three cycles after the first byte
        expect_word(32'hA0B0C0D0, 0);
        send_word(32'hA0B0C0D0, 2'd0);
        lat = 0;
        while (ch_valid_o[0] !== 1'b1 && lat < 20) begin
            @(posedge clk_sys); #1;
            lat++;
        end
        check("stall_first_byte", 32'(ch_data_o[7:0]), 32'hA0);
        ch_busy_i = 3'b001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_sys); #1;
            check("stall_hold", 32'(ch_valid_o), 32'd0);
        end
        ch_busy_i = '0;
        wait_drain("stall_drain");

        // Select change mid-word only affects the next word
        expect_word(32'hC0FFEE01, 0);
        expect_word(32'h12345678, 2);
        send_word(32'hC0FFEE01, 2'd0);
        @(posedge clk_sys); #1;
        send_word(32'h12345678, 2'd2);
        wait_drain("selchg_drain");

        // Select equal to NUM_CH
`ifdef CIPHER_DISPATCH_BYPASS_EN
        expect_word(32'hB1B2B3B4, NCH);
        send_word(32'hB1B2B3B4, 2'd3);
        @(posedge clk_sys); #1;
        check("byp_no_sel_error", 32'(sel_error), 32'd0);
        wait_drain("byp_drain");
        check("byp_no_strobe", 32'(ch_valid_o), 32'd0);
`else
        send_word(32'hB1B2B3B4, 2'd3);
        check("selerr_before", 32'(sel_error), 32'd0);
        @(posedge clk_sys); #1;
        check("selerr_pulse", 32'(sel_error), 32'd1);
        @(posedge clk_sys); #1;
        check("selerr_clear", 32'(sel_error), 32'd0);
        repeat (6) @(posedge clk_sys);
        #1;
        check("selerr_no_strobe", 32'(ch_valid_o), 32'd0);
        check("selerr_fifo_empty", 32'(busy), 32'd0);
`endif

        // Reset during byte 2 with two words queued
        expect_word(32'h0A0B0C0D, 0);
        expect_word(32'h1A1B1C1D, 0);
        expect_word(32'h2A2B2C2D, 0);
        send_word(32'h0A0B0C0D, 2'd0);
        send_word(32'h1A1B1C1D, 2'd0);
        send_word(32'h2A2B2C2D, 2'd0);
        check("mid_rst_byte1", 32'(ch_data_o[7:0]), 32'h0A);
        @(posedge clk_sys); #2;
        rst_n = 1'b0;
        ch_q.delete();
        out_q.delete();
        #1;
        check("mid_rst_ch_valid", 32'(ch_valid_o), 32'd0);
        check("mid_rst_ch_data", 32'(ch_data_o), 32'd0);
        check("mid_rst_valid_o", 32'(valid_o), 32'd0);
        check("mid_rst_data_o", 32'(data_o), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sel_error", 32'(sel_error), 32'd0);
        repeat (2) @(posedge clk_sys);
        #3;
        rst_n = 1'b1;
        repeat (20) @(posedge clk_sys);
        #1;
        check("post_rst_quiet", 32'(ch_valid_o), 32'd0);
        expect_word(32'h55667788, 0);
        send_word(32'h55667788, 2'd0);
        wait_drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cipher_dispatch.md
CIPHER_DISPATCH -- requirements
Module: cipher_dispatch

Interface
REQ-001 SHALL have parameter MST_DWIDTH, default 32, master word width.
REQ-002 SHALL have parameter SYS_DWIDTH, default 8, byte width; MST_DWIDTH is an integer multiple of SYS_DWIDTH; RATIO = MST_DWIDTH/SYS_DWIDTH.
REQ-003 SHALL have parameter NUM_CH, default 3, number of cipher engines (1..8).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, input word FIFO depth (power of two, >=2).
REQ-005 SHALL have parameter SEL_W, default 2, select width; 2**SEL_W > NUM_CH.
REQ-006 clk_sys  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 select  input  SEL_W  channel selection.
REQ-009 data_i  input  MST_DWIDTH  master word; valid_i  input  1  word qualifier.
REQ-010 busy  output  1  FIFO full; word presented while high is dropped.
REQ-011 ch_data_o  output  NUM_CH*SYS_DWIDTH  byte to engine k at slice k; ch_valid_o  output  NUM_CH  one-hot byte strobe.
REQ-012 ch_busy_i  input  NUM_CH  engine k cannot accept a byte.
REQ-013 ch_data_i  input  NUM_CH*SYS_DWIDTH, ch_valid_i  input  NUM_CH  engine results.
REQ-014 data_o  output  SYS_DWIDTH, valid_o  output  1  merged decrypted byte stream.
REQ-015 sel_error  output  1  one-cycle pulse when a word is discarded for an invalid select.

Function
REQ-016 Word accepted when valid_i=1 and busy=0; written to FIFO on that edge.
REQ-017 busy = (FIFO occupancy == FIFO_DEPTH), registered from occupancy; a pop in the same cycle does not clear busy that cycle.
REQ-018 Simultaneous push and pop (not full) SHALL leave occupancy unchanged and preserve order.
REQ-019 Serializer FSM states IDLE, SEND; IDLE->SEND on pop of a word with valid select; SEND->IDLE after last byte when FIFO empty; SEND->SEND (new pop in last-byte cycle) when FIFO non-empty, no bubble.
REQ-020 On pop, select SHALL be latched into cur_sel; select changes mid-word take effect at the next word only.
REQ-021 Bytes SHALL be emitted MSB first, one per cycle, on slice cur_sel, ch_valid_o[cur_sel]=1, other strobes 0, all registered.
REQ-022 While ch_busy_i[cur_sel]=1 the serializer SHALL hold: byte not advanced, ch_valid_o all 0.
REQ-023 Latency: word accepted at edge N with empty FIFO and idle engine -> first byte valid in cycle N+2.
REQ-024 Popped word with select >= NUM_CH (see REQ-029) SHALL be discarded in one cycle; sel_error=1 for that cycle; FSM stays/returns to IDLE.
REQ-025 data_o/valid_o registered: valid_o=1, data_o=ch_data_i[cur_sel] one cycle after ch_valid_i[cur_sel]=1; ch_valid_i of other channels ignored.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear FIFO, occupancy, FSM (IDLE), cur_sel=0, busy=0, ch_data_o=0, ch_valid_o=0, data_o=0, valid_o=0, sel_error=0.
REQ-027 Reset mid-word SHALL discard the partial word and all buffered words; no byte emitted after release until a new word is accepted.

Configuration
REQ-028 Macro CIPHER_DISPATCH_BYPASS_EN SHALL select bypass support.
REQ-029 Defined: select==NUM_CH is valid; bytes go to data_o/valid_o directly one cycle after serialization, no ch_valid_o, ch_busy_i ignored. Undefined: select==NUM_CH is invalid per REQ-024.

Structure
REQ-030 Package cipher_dispatch_pkg SHALL hold the FSM state typedef (IDLE, SEND) and RATIO/byte-index-width helper constants.
REQ-031 FIFO SHALL be sub-module cipher_dispatch_fifo (push, pop, full, empty, occupancy).

Verification
REQ-032 Word 0x11223344, select=1, engines idle -> ch_valid_o=3'b010 cycles N+2..N+5, bytes 0x11,0x22,0x33,0x44.
REQ-033 Five words pushed back-to-back, FIFO_DEPTH=4, ch_busy_i=3'b111 -> busy=1 after fourth, fifth dropped; release busy -> 16 bytes, order preserved, no bubbles.
REQ-034 ch_busy_i[0] high for 3 cycles after byte 1 of 0xA0B0C0D0, select=0 -> bytes 0xA0,0xB0,0xC0,0xD0, no duplicate, no loss.
REQ-035 Select 0->2 mid-word -> current word finishes on channel 0, next word on channel 2.
REQ-036 select=3 (NUM_CH=3), macro undefined -> sel_error one pulse, no ch_valid_o; macro defined -> 4 bytes on data_o, ch_valid_o=0.
REQ-037 rst_n low during byte 2 of a word with 2 words queued -> all outputs 0, no further bytes after release.
